// File: rtl/spi_ram_bridge_if.sv
// SPI pins and RAM strobe port of spi_ram_bridge.
// The bridge uses the master view; the SPI host and RAM side use the slave view.
interface spi_ram_bridge_if;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] ram_rd_addr;
    logic       ram_rd;
    logic [7:0] ram_wr_addr;
    logic       ram_wr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;
    logic       busy;
    logic       err;

    modport master (
        input  spi_sclk, spi_cs_n, spi_mosi, ram_rd_data,
        output spi_miso, ram_rd_addr, ram_rd, ram_wr_addr, ram_wr, ram_wr_data, busy, err
    );

    modport slave (
        output spi_sclk, spi_cs_n, spi_mosi, ram_rd_data,
        input  spi_miso, ram_rd_addr, ram_rd, ram_wr_addr, ram_wr, ram_wr_data, busy, err
    );
endinterface

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 slave giving byte access to a 256x8 RAM through single-cycle rd/wr strobes.
// Optional write protection of addresses >= PROTECT_BASE: define SPI_BRIDGE_WR_PROTECT_EN.
//
// state  | meaning
// IDLE   | waiting for synchronized CS to fall
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the address byte
// WDATA  | shifting in write data, one RAM write per byte
// RDATA  | shifting out read data, prefetching the next byte
// IGNORE | illegal opcode, wait for CS to rise
module spi_ram_bridge #(
    parameter logic [7:0] PROTECT_BASE = 8'hC0
) (
    input logic              clk_system,
    input logic              reset,
    spi_ram_bridge_if.master bus
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t     state, state_nxt;
    logic [2:0] sclk_ff;
    logic [1:0] cs_ff, mosi_ff;
    logic       cs_s, mosi_s, sclk_rise, sclk_fall;
    logic       armed, shifting, byte_done, frame_start, cmd_ok, prot;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh;
    logic [7:0] rx_byte, addr, wr_byte, tx_sh;
    logic       rd_frame, wr_pend, rd_pend, cap_pend;

    assign cs_s      = cs_ff[1];
    assign mosi_s    = mosi_ff[1];
    assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];
    assign rx_byte   = {rx_sh, mosi_s};
    assign cmd_ok    = (rx_byte == 8'h02) || (rx_byte == 8'h03);
    assign shifting  = !cs_s && (state inside {CMD, ADDR, WDATA, RDATA});
    assign byte_done = shifting && sclk_rise && (bit_cnt == 3'd7);
    assign frame_start = (state == IDLE) && (state_nxt == CMD);

`ifdef SPI_BRIDGE_WR_PROTECT_EN
    assign prot = (addr >= PROTECT_BASE);
`else
    // Protection compiled out; the term only keeps PROTECT_BASE referenced.
    assign prot = 1'b0 && (addr >= PROTECT_BASE);
`endif

    // armed is set once CS has been seen high, so a reset mid-frame waits for a fresh CS fall
    assign bus.busy     = armed && !cs_s;
    assign bus.spi_miso = (state == RDATA) && !bus.spi_cs_n && tx_sh[7];

    always_ff @(posedge clk_system or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state != IDLE && cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (armed && !cs_s) state_nxt = CMD;
                CMD:     if (byte_done) state_nxt = cmd_ok ? ADDR : IGNORE;
                ADDR:    if (byte_done) state_nxt = rd_frame ? RDATA : WDATA;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_system or posedge reset) begin
        if (reset) begin
            sclk_ff         <= '0;
            cs_ff           <= '0;
            mosi_ff         <= '0;
            armed           <= 1'b0;
            bit_cnt         <= '0;
            rx_sh           <= '0;
            addr            <= '0;
            wr_byte         <= '0;
            tx_sh           <= '0;
            rd_frame        <= 1'b0;
            wr_pend         <= 1'b0;
            rd_pend         <= 1'b0;
            cap_pend        <= 1'b0;
            bus.ram_rd      <= 1'b0;
            bus.ram_wr      <= 1'b0;
            bus.ram_rd_addr <= '0;
            bus.ram_wr_addr <= '0;
            bus.ram_wr_data <= '0;
            bus.err         <= 1'b0;
        end else begin
            sclk_ff    <= {sclk_ff[1:0], bus.spi_sclk};
            cs_ff      <= {cs_ff[0], bus.spi_cs_n};
            mosi_ff    <= {mosi_ff[0], bus.spi_mosi};
            bus.ram_rd <= 1'b0;
            bus.ram_wr <= 1'b0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            cap_pend   <= bus.ram_rd;
            if (cs_s) armed <= 1'b1;
            if (frame_start) begin
                bit_cnt <= '0;
                tx_sh   <= '0;
                bus.err <= 1'b0;
            end
            if (shifting && sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                rx_sh   <= rx_byte[6:0];
            end
            if (byte_done) begin
                case (state)
                    CMD: begin
                        rd_frame <= (rx_byte == 8'h03);
                        if (!cmd_ok) bus.err <= 1'b1;
                    end
                    ADDR: begin
                        addr    <= rx_byte;
                        rd_pend <= rd_frame;
                    end
                    WDATA: begin
                        wr_byte <= rx_byte;
                        wr_pend <= 1'b1;
                    end
                    RDATA:   rd_pend <= 1'b1;
                    default: rd_pend <= 1'b0;
                endcase
            end
            // Address advances even for a protected byte so later bytes stay aligned
            if (wr_pend) begin
                bus.ram_wr_addr <= addr;
                bus.ram_wr_data <= wr_byte;
                addr            <= addr + 8'd1;
                if (prot) bus.err    <= 1'b1;
                else      bus.ram_wr <= 1'b1;
            end
            if (rd_pend) begin
                bus.ram_rd      <= 1'b1;
                bus.ram_rd_addr <= addr;
                addr            <= addr + 8'd1;
            end
            // A fall with bit_cnt==0 trails the previous byte's last bit and must not shift
            if (cap_pend && state == RDATA)
                tx_sh <= bus.ram_rd_data;
            else if (sclk_fall && state == RDATA && !cs_s && bit_cnt != 3'd0)
                tx_sh <= {tx_sh[6:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_ram_bridge.sv
// Self-checking bench for spi_ram_bridge: table of directed frames, hand-written
// latency/reset sequences and random frames checked against a frame-level model.
module tb_spi_ram_bridge;
    localparam int HALF = 10;
`ifdef SPI_BRIDGE_WR_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef logic [7:0] bytes4_t [4];
    typedef struct {
        logic [7:0] op;
        logic [7:0] addr;
        int         nd;
        bytes4_t    d;
        int         cut;
        int         exp_wr;
        int         exp_rd;
        logic       exp_err;
        bytes4_t    exp_rx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init = 1'b1;
    spi_ram_bridge_if bus();

    spi_ram_bridge #(.PROTECT_BASE(8'hC0)) dut (
        .clk_system(clk),
        .reset     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];
    logic [15:0] wr_q [$];
    int          rd_cnt = 0;
    int          overlap = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        samp_wr [1:HALF];
    logic        samp_miso [1:HALF];

    // RAM: registered read data, valid the cycle after ram_rd
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            bus.ram_rd_data <= 8'h00;
        end else begin
            if (bus.ram_rd) bus.ram_rd_data <= mem[bus.ram_rd_addr];
            if (bus.ram_wr) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        end
    end

    always @(negedge clk) begin
        if (bus.ram_wr) wr_q.push_back({bus.ram_wr_addr, bus.ram_wr_data});
        if (bus.ram_rd) rd_cnt++;
        if (bus.ram_rd && bus.ram_wr) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                samp_wr[k]   = bus.ram_wr;
                samp_miso[k] = bus.spi_miso;
            end
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        wr_q.delete();
        rd_cnt = 0;
        bus.spi_cs_n = 1'b0;
        @(negedge clk);
        check("busy_lat1", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("busy_lat2", 32'(bus.busy), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        @(negedge clk);
        check("miso_cs_high", 32'(bus.spi_miso), 32'd0);
        repeat (6) @(negedge clk);
        check("busy_end", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input int nd,
                             input bytes4_t d, input int cut, output bytes4_t rx);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) rx[i] = 8'h00;
        cs_start();
        spi_byte(op, 8, r);
        check("miso_cmd", 32'(r), 32'd0);
        spi_byte(addr, 8, r);
        check("miso_addr", 32'(r), 32'd0);
        for (int i = 0; i < nd; i++) spi_byte(d[i], (i == nd - 1) ? cut : 8, rx[i]);
        cs_end();
    endtask

    // Frame-level reference: which writes land, which bytes come back, err, read strobes
    task automatic model_check(input logic [7:0] op, input logic [7:0] addr, input int nd,
                               input bytes4_t d, input int cut, input bytes4_t rx);
        logic [15:0] exp_q [$];
        bytes4_t     exp_rx;
        logic [7:0]  a;
        logic        exp_err;
        int          full, exp_rd, ncmp_rx;
        full    = (nd > 0 && cut < 8) ? nd - 1 : nd;
        exp_err = !(op == 8'h02 || op == 8'h03);
        exp_rd  = (op == 8'h03) ? full + 1 : 0;
        for (int i = 0; i < 4; i++) exp_rx[i] = 8'h00;
        for (int i = 0; i < full; i++) begin
            a = addr + 8'(i);
            if (op == 8'h02) begin
                if (PROT && a >= 8'hC0) exp_err = 1'b1;
                else begin
                    exp_mem[a] = d[i];
                    exp_q.push_back({a, d[i]});
                end
            end else if (op == 8'h03) begin
                exp_rx[i] = exp_mem[a];
            end
        end
        check("wr_count", 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check("wr_entry", 32'(wr_q[i]), 32'(exp_q[i]));
        check("rd_count", 32'(rd_cnt), 32'(exp_rd));
        check("err", 32'(bus.err), 32'(exp_err));
        ncmp_rx = (op == 8'h03) ? full : nd;
        for (int i = 0; i < ncmp_rx; i++) check("miso_data", 32'(rx[i]), 32'(exp_rx[i]));
    endtask

    function automatic vec_t mk(logic [7:0] op, logic [7:0] addr, int nd, logic [31:0] dw, int cut,
                                int ew, int er, logic ee, logic [31:0] rw);
        vec_t v;
        v.op = op; v.addr = addr; v.nd = nd; v.cut = cut;
        v.exp_wr = ew; v.exp_rd = er; v.exp_err = ee;
        for (int i = 0; i < 4; i++) begin
            v.d[i]      = dw[31 - 8*i -: 8];
            v.exp_rx[i] = rw[31 - 8*i -: 8];
        end
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        bytes4_t rx;
        run_frame(v.op, v.addr, v.nd, v.d, v.cut, rx);
        check("tbl_wr", 32'(wr_q.size()), 32'(v.exp_wr));
        check("tbl_rd", 32'(rd_cnt), 32'(v.exp_rd));
        check("tbl_err", 32'(bus.err), 32'(v.exp_err));
        for (int i = 0; i < v.nd; i++) check("tbl_rx", 32'(rx[i]), 32'(v.exp_rx[i]));
        model_check(v.op, v.addr, v.nd, v.d, v.cut, rx);
    endtask

    initial begin
        vec_t       tbl [10];
        bytes4_t    d, rx;
        logic [7:0] r, op;
        int         nd, cut;

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", 32'({bus.ram_rd_addr, bus.ram_wr_addr, bus.ram_wr_data, bus.ram_rd,
                                    bus.ram_wr, bus.busy, bus.err, bus.spi_miso}), 32'd0);
        init = 1'b0;
        rst  = 1'b0;
        repeat (6) @(negedge clk);

        tbl[0] = mk(8'h02, 8'h00, 1, 32'h72000000, 8, 1, 0, 1'b0, 32'h0);
        tbl[1] = mk(8'h03, 8'h00, 1, 32'h00000000, 8, 0, 2, 1'b0, 32'h72000000);
        tbl[2] = mk(8'h02, 8'hFE, 3, 32'h11223300, 8, PROT ? 1 : 3, 0, PROT, 32'h0);
        tbl[3] = mk(8'h03, 8'hFE, 3, 32'h00000000, 8, 0, 4, 1'b0, PROT ? 32'h00003300 : 32'h11223300);
        tbl[4] = mk(8'h55, 8'h00, 2, 32'h01020000, 8, 0, 0, 1'b1, 32'h0);
        tbl[5] = mk(8'h02, 8'h01, 1, 32'h33000000, 8, 1, 0, 1'b0, 32'h0);
        tbl[6] = mk(8'h02, 8'h01, 1, 32'hAA000000, 5, 0, 0, 1'b0, 32'h0);
        tbl[7] = mk(8'h03, 8'h01, 1, 32'h00000000, 8, 0, 2, 1'b0, 32'h33000000);
        tbl[8] = mk(8'h02, 8'hBF, 2, 32'h01020000, 8, PROT ? 1 : 2, 0, PROT, 32'h0);
        tbl[9] = mk(8'h03, 8'hBF, 2, 32'h00000000, 8, 0, 3, 1'b0, PROT ? 32'h01000000 : 32'h01020000);
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Write strobe 4 cycles and MISO MSB 6 cycles after the deciding SCLK pin edge
        cs_start();
        spi_byte(8'h02, 8, r);
        spi_byte(8'h10, 8, r);
        spi_byte(8'h80, 8, r);
        check("wr_lat_early", 32'(samp_wr[3]), 32'd0);
        check("wr_lat_on", 32'(samp_wr[4]), 32'd1);
        cs_end();
        d = '{8'h80, 8'h00, 8'h00, 8'h00};
        rx = '{r, 8'h00, 8'h00, 8'h00};
        model_check(8'h02, 8'h10, 1, d, 8, rx);
        cs_start();
        spi_byte(8'h03, 8, r);
        spi_byte(8'h10, 8, r);
        check("miso_lat_early", 32'(samp_miso[5]), 32'd0);
        check("miso_lat_on", 32'(samp_miso[6]), 32'd1);
        spi_byte(8'h00, 8, rx[0]);
        cs_end();
        d = '{8'h00, 8'h00, 8'h00, 8'h00};
        model_check(8'h03, 8'h10, 1, d, 8, rx);

        // Reset in the middle of a write data byte, then bits keep arriving with CS still low
        cs_start();
        spi_byte(8'h02, 8, r);
        spi_byte(8'h01, 8, r);
        spi_byte(8'hAA, 4, r);
        rst = 1'b1;
        @(negedge clk);
        check("reset_midframe", 32'({bus.ram_rd_addr, bus.ram_wr_addr, bus.ram_wr_data, bus.ram_rd,
                                     bus.ram_wr, bus.busy, bus.err, bus.spi_miso}), 32'd0);
        rst = 1'b0;
        spi_byte(8'hAA, 8, r);
        check("reset_busy_low", 32'(bus.busy), 32'd0);
        cs_end();
        check("reset_no_write", 32'(wr_q.size()), 32'd0);
        d = '{8'hAA, 8'h00, 8'h00, 8'h00};
        run_frame(8'h02, 8'h01, 1, d, 8, rx);
        model_check(8'h02, 8'h01, 1, d, 8, rx);
        d = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(8'h03, 8'h01, 1, d, 8, rx);
        check("reset_readback", 32'(rx[0]), 32'hAA);
        model_check(8'h03, 8'h01, 1, d, 8, rx);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = 8'h02;
                4, 5, 6, 7: op = 8'h03;
                default:    op = 8'($urandom_range(0, 255));
            endcase
            nd  = $urandom_range(0, 3);
            cut = (nd > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 8;
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
            r = 8'($urandom_range(0, 255));
            run_frame(op, r, nd, d, cut, rx);
            model_check(op, r, nd, d, cut, rx);
        end

        check("rd_wr_overlap", 32'(overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
